pm_resp: RTL and testbench
==========================

// Module: pm_resp
// PURPOSE
//  Program-memory responder: the memory end of the sequencer fetch interface (ps_pm_cslt/ps_pm_wrb/ps_pm_add -> pm_ps_op).
//  Holds the instruction store. Serves one fetch per clock with registered read data.
//  After reset it can optionally boot-load the store from a byte stream. While boot is running it holds stallb low to stall the pipeline.
// PARAMETERS
//  PM_AW    16   width of ps_pm_add
//  PM_DEPTH 256  number of 32-bit instruction words implemented (addresses 0..PM_DEPTH-1)
//  PM_DW    32   instruction width
// PORTS
//  clk          in   1      single clock; all state updates on posedge
//  rst          in   1      asynchronous, active-low reset
//  boot_en      in   1      sampled while rst low; 1 = boot-load after reset, 0 = start in RUN
//  ps_pm_cslt   in   1      chip select from sequencer (fetch or write request)
//  ps_pm_wrb    in   1      1 = read, 0 = write (active-low write)
//  ps_pm_add    in   PM_AW  word address
//  ps_pm_wdt    in   PM_DW  write data, used when cslt=1 and wrb=0
//  pm_ps_op     out  PM_DW  registered instruction to sequencer
//  ld_vld       in   1      boot byte valid
//  ld_byte      in   8      boot byte
//  ld_rdy       out  1      boot byte accepted (handshake completes when ld_vld & ld_rdy)
//  stallb       out  1      0 = pipeline stall (boot in progress)
//  pm_err       out  1      one-cycle pulse: access at address >= PM_DEPTH
//  boot_done    out  1      level; 1 once RUN is entered
// BEHAVIOUR
//  Reset values: pm_ps_op=0, ld_rdy=0, stallb=0, pm_err=0, boot_done=0, byte and word counters 0.
//  Reset does not clear the store contents. Reset asserted mid-boot aborts the load; the next release restarts it from CNT_HI.
//  FSM states:
//   CNT_HI  ld_rdy=1; accepted byte -> wcnt[15:8]; go to CNT_LO.
//   CNT_LO  ld_rdy=1; accepted byte -> wcnt[7:0].
//           If the count is 0, go to RUN. Otherwise waddr=0, byte_idx=0, go to DATA.
//   DATA    ld_rdy=1; bytes arrive MSB first and are shifted into a 32-bit assembly register.
//           On the 4th byte, write mem[waddr]. Then waddr++ and wcnt--.
//           When wcnt reaches 0 on that write, go to RUN.
//           Words whose waddr >= PM_DEPTH are discarded and pulse pm_err.
//   RUN     ld_rdy=0; stallb=1; boot_done=1. ld_vld is ignored. Terminal until reset.
//  Leaving reset goes to CNT_HI if boot_en was 1, otherwise straight to RUN.
//  stallb=0 in CNT_HI, CNT_LO and DATA.
//  Handshake: a byte is consumed only in a cycle with ld_vld & ld_rdy. A low ld_vld inserts wait cycles with no state change.
//  Fetch, RUN only:
//   - Read: cslt=1, wrb=1 at edge N gives pm_ps_op = mem[ps_pm_add] after edge N (1-cycle latency).
//   - cslt=0: pm_ps_op holds its last value (stall/idle friendly).
//   - Read at an address >= PM_DEPTH returns 32'b0 (NOP) and pulses pm_err.
//  Write, RUN only: cslt=1, wrb=0 writes ps_pm_wdt into mem[add]. pm_ps_op holds.
//   Out-of-range writes are dropped and pulse pm_err.
//   A read of the same address on the next cycle returns the new data.
//  Any cslt activity outside RUN is ignored (no read, no write, no pm_err) and pm_ps_op holds.
//  Address compare uses the full PM_AW bits. Upper bits are never truncated or aliased.
//  Word counter is 16 bits, so at most 65535 words per boot. Words beyond PM_DEPTH count down but are dropped.
// STRUCTURE
//  Shared package pm_pkg: PM_DW, PM_AW, PM_NOP=32'h0, FSM state encoding {CNT_HI,CNT_LO,DATA,RUN}.
//  One sub-module, pm_ram: single-port synchronous RAM with registered read and write-enable.
//   Read and write share one port and are muxed between loader and sequencer by FSM state.
//  Top level holds the FSM, counters, byte assembler, range check and output registers.
// TESTING
//  1 boot_en=0, release rst -> same cycle stallb=1, boot_done=1; cslt=1, wrb=1, add=5 -> pm_ps_op=mem[5] after 1 edge.
//  2 boot_en=1; bytes 00 02 | 12 34 56 78 | 9A BC DE F0 ->
//    stallb=0 for the whole load, then 1; mem[0]=32'h12345678, mem[1]=32'h9ABCDEF0;
//    fetches of add=0 and add=1 return those words.
//  3 Same stream as 2 with ld_vld deasserted for 3 cycles between every byte -> identical memory contents; no extra bytes consumed.
//  4 RUN: write add=7, data 32'hCAFEF00D, then read add=7 on the next cycle -> pm_ps_op=32'hCAFEF00D. cslt=0 for 4 cycles -> pm_ps_op unchanged.
//  5 Read add=PM_DEPTH (256) -> pm_ps_op=0, pm_err high for exactly 1 cycle. Write add=300 -> no store change, pm_err pulse.
//  6 Boot with count 00 00 -> RUN right after CNT_LO. Assert rst after 5 DATA bytes of a 2-word boot ->
//    outputs return to reset values; the new boot starts at CNT_HI and mem[0] is overwritten.

Source files
------------

// File: rtl/pm_pkg.sv
// Shared definitions for the program-memory responder.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package pm_pkg;

  localparam int          PM_DW  = 32;
  localparam int          PM_AW  = 16;
  localparam logic [31:0] PM_NOP = 32'h0;

  typedef enum logic [1:0] {
    CNT_HI = 2'd0,
    CNT_LO = 2'd1,
    DATA   = 2'd2,
    RUN    = 2'd3
  } pm_state_t;

endpackage

// File: rtl/pm_ram.sv
// Single-port instruction store: one read or one write per clock.
// Latency: read data registered, valid one edge after an enabled read.
// Backpressure: none; rdata holds whenever no read is issued.
module pm_ram
  import pm_pkg::*;
#(
  parameter int DW    = PM_DW,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // store write; the array has no reset so program contents survive reset
  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  // registered read port; only an enabled read updates it, so it holds otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              rdata <= '0;
    else if (en && !we)    rdata <= mem[addr];
  end

endmodule

// File: rtl/pm_resp.sv
// Program-memory responder: boot-loads the store from a byte stream, then serves sequencer fetches/writes.
// Latency: fetch data and pm_err appear one edge after the request; boot words are written on their 4th byte.
// Backpressure: ld_rdy is high in every boot state; stallb holds the pipeline low until RUN.
module pm_resp #(
  parameter int PM_AW    = pm_pkg::PM_AW,
  parameter int PM_DEPTH = 256,
  parameter int PM_DW    = pm_pkg::PM_DW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             boot_en,
  input  logic             ps_pm_cslt,
  input  logic             ps_pm_wrb,
  input  logic [PM_AW-1:0] ps_pm_add,
  input  logic [PM_DW-1:0] ps_pm_wdt,
  output logic [PM_DW-1:0] pm_ps_op,
  input  logic             ld_vld,
  input  logic [7:0]       ld_byte,
  output logic             ld_rdy,
  output logic             stallb,
  output logic             pm_err,
  output logic             boot_done
);
  import pm_pkg::*;

  localparam int               RAW     = $clog2(PM_DEPTH);
  // depth constants one bit wider than the address so PM_DEPTH == 2**width still compares correctly
  localparam logic [PM_AW:0]   DEPTH_A = PM_DEPTH[PM_AW:0];
  localparam logic [16:0]      DEPTH_W = PM_DEPTH[16:0];

  pm_state_t        state;
  logic [15:0]      wcnt;
  logic [15:0]      waddr;
  logic [1:0]       byte_idx;
  logic [23:0]      asm_q;
  logic             nop_q;
  logic [PM_DW-1:0] ram_rdata;

  logic             run;
  logic             act;
  logic             add_ok;
  logic             wad_ok;
  logic             word_wr;
  logic [31:0]      ld_word;
  logic             ram_en;
  logic             ram_we;
  logic [RAW-1:0]   ram_addr;
  logic [PM_DW-1:0] ram_wdata;

  // range checks on full address widths, and the shared RAM port muxed by FSM state
  always_comb begin
    run       = (state == RUN);
    act       = rst && run;
    add_ok    = ({1'b0, ps_pm_add} < DEPTH_A);
    wad_ok    = ({1'b0, waddr} < DEPTH_W);
    ld_word   = {asm_q, ld_byte};
    word_wr   = rst && ld_vld && (state == DATA) && (byte_idx == 2'd3);
    ram_en    = word_wr && wad_ok;
    ram_we    = 1'b1;
    ram_addr  = waddr[RAW-1:0];
    ram_wdata = PM_DW'(ld_word);
    if (act) begin
      ram_en    = ps_pm_cslt && add_ok;
      ram_we    = !ps_pm_wrb;
      ram_addr  = ps_pm_add[RAW-1:0];
      ram_wdata = ps_pm_wdt;
    end
  end

  // status outputs decode the registered state; gating with rst forces their reset values
  assign stallb    = act;
  assign boot_done = act;
  assign ld_rdy    = rst && !run;

  // boot loader FSM: word count, byte assembly, load address and the error pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // boot_en is a strap: whatever it reads during reset selects the start state
      state    <= boot_en ? CNT_HI : RUN;
      wcnt     <= '0;
      waddr    <= '0;
      byte_idx <= '0;
      asm_q    <= '0;
      pm_err   <= 1'b0;
    end else begin
      pm_err <= 1'b0;
      case (state)
        CNT_HI: if (ld_vld) begin
          wcnt[15:8] <= ld_byte;
          state      <= CNT_LO;
        end
        CNT_LO: if (ld_vld) begin
          wcnt[7:0] <= ld_byte;
          waddr     <= '0;
          byte_idx  <= '0;
          state     <= ({wcnt[15:8], ld_byte} == 16'd0) ? RUN : DATA;
        end
        DATA: if (ld_vld) begin
          asm_q    <= ld_word[23:0];
          byte_idx <= byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            waddr  <= waddr + 16'd1;
            wcnt   <= wcnt - 16'd1;
            pm_err <= !wad_ok;
            if (wcnt == 16'd1) state <= RUN;
          end
        end
        RUN:     pm_err <= ps_pm_cslt && !add_ok;
        default: state  <= RUN;
      endcase
    end
  end

  // out-of-range reads return NOP without touching the RAM's read register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 nop_q <= 1'b0;
    else if (act && ps_pm_cslt && ps_pm_wrb)  nop_q <= !add_ok;
  end

  assign pm_ps_op = nop_q ? PM_DW'(PM_NOP) : ram_rdata;

  pm_ram #(
    .DW    (PM_DW),
    .DEPTH (PM_DEPTH),
    .AW    (RAW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_pm_resp.sv
// Bench for pm_resp: reset, fetch/write, range errors, boot loads with gaps, zero count, reset mid-boot.
// Latency: expects fetch data one edge after the request.
// Backpressure: boot bytes are presented with ld_vld and held until ld_rdy.
module tb_pm_resp;

  localparam int DEPTH = 256;

  logic        clk     = 1'b0;
  logic        rst     = 1'b1;
  logic        boot_en = 1'b0;
  logic        cslt    = 1'b0;
  logic        wrb     = 1'b1;
  logic [15:0] add     = 16'h0;
  logic [31:0] wdt     = 32'h0;
  logic [31:0] op;
  logic        ld_vld  = 1'b0;
  logic [7:0]  ld_byte = 8'h0;
  logic        ld_rdy;
  logic        stallb;
  logic        pm_err;
  logic        boot_done;

  int tests = 0;
  int fails = 0;

  // reference store: plain array of words plus a written-yet flag per address
  logic [31:0] mdl   [DEPTH];
  bit          known [DEPTH];
  logic [31:0] exp_op = 32'h0;

  // observations gathered while a boot stream is sent
  int n_acc, n_err, n_stall_bad;

  always #5 clk = ~clk;

  pm_resp #(.PM_AW(16), .PM_DEPTH(DEPTH), .PM_DW(32)) dut (
    .clk(clk), .rst(rst), .boot_en(boot_en),
    .ps_pm_cslt(cslt), .ps_pm_wrb(wrb), .ps_pm_add(add), .ps_pm_wdt(wdt),
    .pm_ps_op(op), .ld_vld(ld_vld), .ld_byte(ld_byte), .ld_rdy(ld_rdy),
    .stallb(stallb), .pm_err(pm_err), .boot_done(boot_done)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1);
  end

  // ---------------- drivers (no checking) ----------------
  task automatic do_reset(input logic be);
    @(negedge clk);
    rst = 1'b0; boot_en = be; cslt = 1'b0; wrb = 1'b1; ld_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    exp_op = 32'h0;
  endtask

  task automatic rd(input logic [15:0] a);
    @(negedge clk); cslt = 1'b1; wrb = 1'b1; add = a;
    @(negedge clk); cslt = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk); cslt = 1'b1; wrb = 1'b0; add = a; wdt = d;
    @(negedge clk); cslt = 1'b0; wrb = 1'b1;
  endtask

  // count + words, each word MSB first
  task automatic build(input logic [31:0] w[$], input int cnt, output logic [7:0] s[$]);
    s = {};
    s.push_back(8'(cnt >> 8));
    s.push_back(8'(cnt));
    foreach (w[k]) for (int b = 3; b >= 0; b--) s.push_back(8'(w[k] >> (8 * b)));
  endtask

  // a completed boot leaves word k at address k, anything past the store is lost
  task automatic model_boot(input logic [31:0] w[$]);
    foreach (w[k]) if (k < DEPTH) begin mdl[k] = w[k]; known[k] = 1'b1; end
  endtask

  task automatic send_stream(input logic [7:0] bytes[$], input int gap);
    n_acc = 0; n_err = 0; n_stall_bad = 0;
    @(negedge clk);
    foreach (bytes[i]) begin
      int budget = 0;
      ld_vld = 1'b1; ld_byte = bytes[i];
      while (ld_rdy !== 1'b1 && budget < 20) begin @(negedge clk); budget++; end
      if (ld_rdy !== 1'b1) begin
        tests++; fails++;
        $display("FAIL ld_rdy_timeout byte %0d: ld_rdy=%b required 1", i, ld_rdy);
        ld_vld = 1'b0;
        return;
      end
      if (stallb !== 1'b0) n_stall_bad++;
      @(negedge clk);
      n_acc++;
      ld_vld = 1'b0; ld_byte = 8'($urandom);
      if (pm_err === 1'b1) n_err++;
      for (int g = 0; g < gap; g++) begin
        if (i != bytes.size() - 1 && stallb !== 1'b0) n_stall_bad++;
        @(negedge clk);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; boot_en = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (op !== 32'h0 || ld_rdy !== 1'b0 || stallb !== 1'b0 || pm_err !== 1'b0 || boot_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: op=%h ld_rdy=%b stallb=%b pm_err=%b boot_done=%b required 0", op, ld_rdy, stallb, pm_err, boot_done);
    end
    #2; rst = 1'b1; #1;
    tests++;
    if (stallb !== 1'b1 || boot_done !== 1'b1 || ld_rdy !== 1'b0) begin
      fails++;
      $display("FAIL release_no_boot: stallb=%b boot_done=%b ld_rdy=%b required 1 1 0", stallb, boot_done, ld_rdy);
    end
  endtask

  task automatic test_fetch();
    logic [31:0] d;
    logic [15:0] a;
    d = $urandom; wr(16'd5, d); mdl[5] = d; known[5] = 1'b1;
    tests++;
    if (op !== exp_op) begin fails++; $display("FAIL op_hold_on_write: op=%h required %h", op, exp_op); end
    rd(16'd5); exp_op = d;
    tests++;
    if (op !== exp_op || pm_err !== 1'b0) begin
      fails++; $display("FAIL fetch_add5: op=%h pm_err=%b required %h 0", op, pm_err, exp_op);
    end
    for (int k = 0; k < 24; k++) begin
      a = 16'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 1) == 0 || !known[a]) begin
        d = $urandom; wr(a, d); mdl[a] = d; known[a] = 1'b1;
      end else begin
        rd(a); exp_op = mdl[a];
      end
      tests++;
      if (op !== exp_op || pm_err !== 1'b0) begin
        fails++; $display("FAIL rand_access %0d add=%0d: op=%h pm_err=%b required %h 0", k, a, op, pm_err, exp_op);
      end
    end
  endtask

  task automatic test_write_read();
    @(negedge clk); cslt = 1'b1; wrb = 1'b0; add = 16'd7; wdt = 32'hCAFEF00D;
    @(negedge clk); wrb = 1'b1;
    @(negedge clk); cslt = 1'b0;
    mdl[7] = 32'hCAFEF00D; known[7] = 1'b1; exp_op = 32'hCAFEF00D;
    tests++;
    if (op !== exp_op || pm_err !== 1'b0) begin
      fails++; $display("FAIL write_then_read: op=%h pm_err=%b required %h 0", op, pm_err, exp_op);
    end
    for (int k = 0; k < 4; k++) begin
      add = 16'($urandom); wrb = 1'($urandom); wdt = $urandom;
      @(negedge clk);
      tests++;
      if (op !== exp_op) begin fails++; $display("FAIL idle_hold cycle %0d: op=%h required %h", k, op, exp_op); end
    end
    wrb = 1'b1;
  endtask

  task automatic test_oor();
    logic [15:0] a;
    rd(16'(DEPTH)); exp_op = 32'h0;
    tests++;
    if (op !== 32'h0 || pm_err !== 1'b1) begin
      fails++; $display("FAIL oor_read_256: op=%h pm_err=%b required 0 1", op, pm_err);
    end
    @(negedge clk);
    tests++;
    if (pm_err !== 1'b0) begin fails++; $display("FAIL pm_err_one_cycle: pm_err=%b required 0", pm_err); end
    a = 16'($urandom_range(DEPTH, 65535));
    rd(a);
    tests++;
    if (op !== 32'h0 || pm_err !== 1'b1) begin
      fails++; $display("FAIL oor_read_rand add=%0d: op=%h pm_err=%b required 0 1", a, op, pm_err);
    end
    wr(16'd44, 32'h44444444); mdl[44] = 32'h44444444; known[44] = 1'b1;
    wr(16'd300, 32'hDEADBEEF);
    tests++;
    if (pm_err !== 1'b1 || op !== exp_op) begin
      fails++; $display("FAIL oor_write_300: pm_err=%b op=%h required 1 %h", pm_err, op, exp_op);
    end
    wr(16'h8005, 32'hBADBAD00);
    rd(16'd44); exp_op = mdl[44];
    tests++;
    if (op !== exp_op || pm_err !== 1'b0) begin
      fails++; $display("FAIL no_alias_44: op=%h pm_err=%b required %h 0", op, pm_err, exp_op);
    end
    rd(16'd5); exp_op = mdl[5];
    tests++;
    if (op !== exp_op) begin fails++; $display("FAIL no_alias_5: op=%h required %h", op, exp_op); end
  endtask

  task automatic test_boot(input int gap);
    logic [31:0] w[$];
    logic [7:0]  s[$];
    int bad;
    w = {32'h12345678, 32'h9ABCDEF0};
    build(w, 2, s);
    do_reset(1'b1);
    tests++;
    if (stallb !== 1'b0 || boot_done !== 1'b0 || ld_rdy !== 1'b1) begin
      fails++; $display("FAIL boot_start gap=%0d: stallb=%b boot_done=%b ld_rdy=%b required 0 0 1", gap, stallb, boot_done, ld_rdy);
    end
    send_stream(s, gap);
    model_boot(w);
    tests++;
    if (n_stall_bad != 0 || n_acc != 10 || n_err != 0) begin
      fails++; $display("FAIL boot_stream gap=%0d: stall_high=%0d accepted=%0d errs=%0d required 0 10 0", gap, n_stall_bad, n_acc, n_err);
    end
    tests++;
    if (stallb !== 1'b1 || boot_done !== 1'b1) begin
      fails++; $display("FAIL boot_end gap=%0d: stallb=%b boot_done=%b required 1 1", gap, stallb, boot_done);
    end
    bad = 0; ld_vld = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ld_byte = 8'($urandom);
      if (ld_rdy !== 1'b0) bad++;
      @(negedge clk);
    end
    ld_vld = 1'b0;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL extra_bytes gap=%0d: ld_rdy high %0d cycles required 0", gap, bad); end
    for (int k = 0; k < 2; k++) begin
      rd(16'(k)); exp_op = mdl[k];
      tests++;
      if (op !== exp_op) begin fails++; $display("FAIL boot_word%0d gap=%0d: op=%h required %h", k, gap, op, exp_op); end
    end
  endtask

  task automatic test_random_boot();
    logic [31:0] w[$];
    logic [7:0]  s[$];
    int cnt, lim;
    for (int r = 0; r < 2; r++) begin
      cnt = (r == 0) ? $urandom_range(3, 8) : DEPTH + 2;
      w = {};
      for (int k = 0; k < cnt; k++) w.push_back($urandom);
      build(w, cnt, s);
      do_reset(1'b1);
      send_stream(s, (r == 0) ? $urandom_range(1, 2) : 0);
      model_boot(w);
      tests++;
      if (n_acc != s.size() || n_stall_bad != 0 || stallb !== 1'b1) begin
        fails++; $display("FAIL rand_boot%0d: accepted=%0d stall_high=%0d stallb=%b required %0d 0 1", r, n_acc, n_stall_bad, stallb, s.size());
      end
      tests++;
      if (n_err != ((cnt > DEPTH) ? cnt - DEPTH : 0)) begin
        fails++; $display("FAIL rand_boot_err%0d: pulses=%0d required %0d", r, n_err, (cnt > DEPTH) ? cnt - DEPTH : 0);
      end
      lim = (cnt < DEPTH) ? cnt : DEPTH;
      for (int k = 0; k < lim; k++) begin
        rd(16'(k)); exp_op = mdl[k];
        tests++;
        if (op !== exp_op || pm_err !== 1'b0) begin
          fails++; $display("FAIL rand_boot%0d_word%0d: op=%h pm_err=%b required %h 0", r, k, op, pm_err, exp_op);
        end
      end
    end
  endtask

  task automatic test_zero_count();
    logic [7:0] s[$];
    s = {8'h00, 8'h00};
    do_reset(1'b1);
    send_stream(s, 0);
    tests++;
    if (stallb !== 1'b1 || boot_done !== 1'b1 || ld_rdy !== 1'b0) begin
      fails++; $display("FAIL zero_count: stallb=%b boot_done=%b ld_rdy=%b required 1 1 0", stallb, boot_done, ld_rdy);
    end
    rd(16'd0); exp_op = mdl[0];
    tests++;
    if (op !== exp_op) begin fails++; $display("FAIL zero_count_store: op=%h required %h", op, exp_op); end
  endtask

  task automatic test_reset_midboot();
    logic [31:0] w[$];
    logic [7:0]  s[$];
    w = {32'hA1B2C3D4, 32'h55667788};
    build(w, 2, s);
    s = s[0:6];
    do_reset(1'b1);
    send_stream(s, 0);
    mdl[0] = w[0]; known[0] = 1'b1;
    rst = 1'b0; #1;
    tests++;
    if (op !== 32'h0 || ld_rdy !== 1'b0 || stallb !== 1'b0 || pm_err !== 1'b0 || boot_done !== 1'b0) begin
      fails++; $display("FAIL midboot_reset: op=%h ld_rdy=%b stallb=%b pm_err=%b boot_done=%b required 0", op, ld_rdy, stallb, pm_err, boot_done);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1; #1; exp_op = 32'h0;
    tests++;
    if (ld_rdy !== 1'b1 || stallb !== 1'b0 || boot_done !== 1'b0) begin
      fails++; $display("FAIL midboot_restart: ld_rdy=%b stallb=%b boot_done=%b required 1 0 0", ld_rdy, stallb, boot_done);
    end
    w = {32'h0BADF00D};
    build(w, 1, s);
    send_stream(s, 1);
    model_boot(w);
    for (int k = 0; k < 2; k++) begin
      rd(16'(k)); exp_op = mdl[k];
      tests++;
      if (op !== exp_op) begin fails++; $display("FAIL midboot_word%0d: op=%h required %h", k, op, exp_op); end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_write_read();
    test_oor();
    test_boot(0);
    // scribble over the boot words so the gapped reload has to rewrite them
    wr(16'd0, 32'h0); wr(16'd1, 32'h1);
    mdl[0] = 32'h0; mdl[1] = 32'h1; known[0] = 1'b1; known[1] = 1'b1;
    test_boot(3);
    test_random_boot();
    test_zero_count();
    test_reset_midboot();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
